// File: rtl/fmeas_pkg.sv
// Shared types and helpers for the multi-channel frequency/period meter.
//   state_t : one-hot FSM encoding (IDLE, ARM, MEASURE, DONE)
//   mode_t  : measurement mode latched with start (frequency gate / period)
//   max_int : larger of two integers, used to size the shared gate/timeout counter
package fmeas_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'b0001,
    ARM     = 4'b0010,
    MEASURE = 4'b0100,
    DONE    = 4'b1000
  } state_t;

  typedef enum logic {
    MODE_FREQ   = 1'b0,
    MODE_PERIOD = 1'b1
  } mode_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fmeas_channel.sv
// One measurement lane: synchroniser, rising-edge detector, saturating result
// counter and period-complete tracking.
// Ports:
//   clk, rst_n : measurement clock, asynchronous active-low reset
//   wave       : asynchronous wave input for this lane
//   clear      : high while the FSM is in ARM; clears counter/ovf/complete state
//   measure    : high while the FSM is in MEASURE; enables counting
//   mode       : latched measurement mode
//   count      : current (saturating) result count
//   ovf        : count has reached its maximum value
//   complete   : period mode only, NUM_PERIODS periods have been timed
module fmeas_channel
  import fmeas_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int NUM_PERIODS = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wave,
  input  logic             clear,
  input  logic             measure,
  input  mode_t            mode,
  output logic [CNT_W-1:0] count,
  output logic             ovf,
  output logic             complete
);

  localparam int              PER_W    = (NUM_PERIODS > 1) ? $clog2(NUM_PERIODS) : 1;
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(NUM_PERIODS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   ovf_q, ovf_d;
  logic                   armed_q, armed_d;
  logic                   complete_q, complete_d;
  logic [PER_W-1:0]       per_cnt_q, per_cnt_d;

  logic synced;
  logic rise;
  logic inc;

  assign synced = sync_q[SYNC_STAGES-1];
  assign rise   = synced & ~prev_q;

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], wave};
    // prev follows the synced wave every cycle, so on leaving ARM it already
    // holds the current level and no spurious first edge is seen.
    prev_d     = synced;
    count_d    = count_q;
    ovf_d      = ovf_q;
    armed_d    = armed_q;
    complete_d = complete_q;
    per_cnt_d  = per_cnt_q;
    inc        = 1'b0;

    if (clear) begin
      count_d    = '0;
      ovf_d      = 1'b0;
      armed_d    = 1'b0;
      complete_d = 1'b0;
      per_cnt_d  = '0;
    end else if (measure) begin
      if (mode == MODE_FREQ) begin
        inc = rise;
      end else if (!complete_q) begin
        if (armed_q) begin
          // Count every clk from the cycle after the arming edge up to and
          // including the cycle of the completing edge.
          inc = 1'b1;
          if (rise) begin
            if (per_cnt_q == PER_LAST) begin
              complete_d = 1'b1;
            end else begin
              per_cnt_d = per_cnt_q + PER_W'(1);
            end
          end
        end else if (rise) begin
          armed_d = 1'b1;
        end
      end

      if (inc) begin
        if (count_q != CNT_MAX) begin
          count_d = count_q + CNT_W'(1);
        end
        if (count_d == CNT_MAX) begin
          ovf_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      prev_q     <= 1'b0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      armed_q    <= 1'b0;
      complete_q <= 1'b0;
      per_cnt_q  <= '0;
    end else begin
      sync_q     <= sync_d;
      prev_q     <= prev_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      armed_q    <= armed_d;
      complete_q <= complete_d;
      per_cnt_q  <= per_cnt_d;
    end
  end

  assign count    = count_q;
  assign ovf      = ovf_q;
  assign complete = complete_q;

endmodule

// File: rtl/multi_channel_freq_meter.sv
// Multi-channel frequency / period meter, single clock domain.
// Frequency mode counts synced rising edges over GATE_CYCLES clocks; period
// mode counts clk cycles across NUM_PERIODS wave periods per channel.
// Optional feature macro: FMEAS_TIMEOUT_EN -- when defined, period mode gives
// up after TIMEOUT_CYCLES and flags incomplete channels on `timeout`;
// when undefined, `timeout` is tied to 0 (TIMEOUT_CYCLES then only sizes the
// shared cycle counter).
// Ports:
//   clk, rst_n : measurement clock, asynchronous active-low reset
//   wave       : N_CH asynchronous wave inputs
//   start      : start request, honoured only in IDLE
//   mode       : 0 frequency, 1 period; latched with start
//   abort      : cancel measurement in ARM/MEASURE
//   busy       : state != IDLE
//   done       : one-cycle pulse, results valid from this cycle
//   val        : per-channel result, channel i at [i*CNT_W +: CNT_W]
//   ovf        : per-channel saturation flag
//   timeout    : per-channel incomplete-at-timeout flag
module multi_channel_freq_meter
  import fmeas_pkg::*;
#(
  parameter int N_CH           = 4,
  parameter int CNT_W          = 32,
  parameter int GATE_CYCLES    = 1000,
  parameter int NUM_PERIODS    = 1,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1 << 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       wave,
  input  logic                  start,
  input  logic                  mode,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [N_CH*CNT_W-1:0] val,
  output logic [N_CH-1:0]       ovf,
  output logic [N_CH-1:0]       timeout
);

  localparam int TMR_MAX = max_int(GATE_CYCLES, TIMEOUT_CYCLES);
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  state_t           state_q, state_d;
  mode_t            mode_q, mode_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             load_results;

  logic [N_CH*CNT_W-1:0] val_q, val_d;
  logic [N_CH-1:0]       ovf_q, ovf_d;

  logic [N_CH*CNT_W-1:0] count_w;
  logic [N_CH-1:0]       ovf_w;
  logic [N_CH-1:0]       complete_w;
  logic                  all_complete;

  logic ch_clear;
  logic ch_measure;

  assign ch_clear     = (state_q == ARM);
  assign ch_measure   = (state_q == MEASURE);
  assign all_complete = &complete_w;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      fmeas_channel #(
        .CNT_W       (CNT_W),
        .NUM_PERIODS (NUM_PERIODS),
        .SYNC_STAGES (SYNC_STAGES)
      ) u_ch (
        .clk      (clk),
        .rst_n    (rst_n),
        .wave     (wave[gi]),
        .clear    (ch_clear),
        .measure  (ch_measure),
        .mode     (mode_q),
        .count    (count_w[gi*CNT_W +: CNT_W]),
        .ovf      (ovf_w[gi]),
        .complete (complete_w[gi])
      );
    end
  endgenerate

  // FSM next state, shared gate/timeout counter and result-load strobe.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    tmr_d        = tmr_q;
    load_results = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d  = mode_t'(mode);
          state_d = ARM;
        end
      end
      ARM: begin
        tmr_d   = '0;
        state_d = abort ? IDLE : MEASURE;
      end
      MEASURE: begin
        if (tmr_q != {TMR_W{1'b1}}) begin
          tmr_d = tmr_q + TMR_W'(1);
        end
        if (abort) begin
          state_d = IDLE;
        end else if (mode_q == MODE_FREQ) begin
          if (tmr_q == TMR_W'(GATE_CYCLES - 1)) begin
            state_d      = DONE;
            load_results = 1'b1;
          end
        end else begin
          if (all_complete) begin
            state_d      = DONE;
            load_results = 1'b1;
          end
`ifdef FMEAS_TIMEOUT_EN
          else if (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
            state_d      = DONE;
            load_results = 1'b1;
          end
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef FMEAS_TIMEOUT_EN
  logic [N_CH-1:0] timeout_q, timeout_d;

  always_comb begin
    val_d     = val_q;
    ovf_d     = ovf_q;
    timeout_d = timeout_q;
    if (load_results) begin
      for (int i = 0; i < N_CH; i++) begin
        // Only a period run can end with channels still incomplete.
        if ((mode_q == MODE_PERIOD) && !complete_w[i]) begin
          val_d[i*CNT_W +: CNT_W] = '0;
          ovf_d[i]                = 1'b0;
          timeout_d[i]            = 1'b1;
        end else begin
          val_d[i*CNT_W +: CNT_W] = count_w[i*CNT_W +: CNT_W];
          ovf_d[i]                = ovf_w[i];
          timeout_d[i]            = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_q <= '0;
    end else begin
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  always_comb begin
    val_d = val_q;
    ovf_d = ovf_q;
    if (load_results) begin
      val_d = count_w;
      ovf_d = ovf_w;
    end
  end

  assign timeout = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= MODE_FREQ;
      tmr_q   <= '0;
      val_q   <= '0;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      tmr_q   <= tmr_d;
      val_q   <= val_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign val  = val_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_multi_channel_freq_meter.sv
// Directed bench for multi_channel_freq_meter. Two instances share clock,
// reset and the start/mode/abort controls:
//   dut1 : CNT_W=16, NUM_PERIODS=4 (frequency, period, abort, reset tests)
//   dut2 : CNT_W=8,  NUM_PERIODS=1 (period-mode saturation test)
// The FMEAS_TIMEOUT_EN step runs only when that macro is defined.
module tb_multi_channel_freq_meter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, mode, abort;
  logic [3:0]  wave1, wave2;
  logic        busy1, done1, busy2, done2;
  logic [63:0] val1;
  logic [31:0] val2;
  logic [3:0]  ovf1, ovf2, tmo1, tmo2;

  int tests = 0;
  int fails = 0;

  int per [4];
  int ph  [4];
  int per2 = 300;
  int ph2  = 0;
  int exp_f [4] = '{100, 50, 20, 1};

  always #5 clk = ~clk;

  // Wave generators, updated on the falling edge away from DUT sampling.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (per[i] == 0) begin
        wave1[i] = 1'b0;
        ph[i]    = 0;
      end else begin
        wave1[i] = (ph[i] < per[i] / 2);
        ph[i]    = (ph[i] + 1 >= per[i]) ? 0 : ph[i] + 1;
      end
    end
    wave2 = {4{(ph2 < per2 / 2)}};
    ph2   = (ph2 + 1 >= per2) ? 0 : ph2 + 1;
  end

  multi_channel_freq_meter #(
    .N_CH(4), .CNT_W(16), .GATE_CYCLES(1000), .NUM_PERIODS(4),
    .SYNC_STAGES(2), .TIMEOUT_CYCLES(5000)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .wave(wave1), .start(start), .mode(mode),
    .abort(abort), .busy(busy1), .done(done1), .val(val1), .ovf(ovf1),
    .timeout(tmo1)
  );

  multi_channel_freq_meter #(
    .N_CH(4), .CNT_W(8), .GATE_CYCLES(1000), .NUM_PERIODS(1),
    .SYNC_STAGES(2), .TIMEOUT_CYCLES(5000)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .wave(wave2), .start(start), .mode(mode),
    .abort(abort), .busy(busy2), .done(done2), .val(val2), .ovf(ovf2),
    .timeout(tmo2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one cycle; busy must be high the cycle after.
  task automatic kick(input logic m);
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_start", {63'd0, busy1}, 64'd1);
  endtask

  // Latency in cycles counted with the start cycle as cycle 0; -1 on expiry.
  task automatic wait_done1(input int limit, output int lat);
    lat = -1;
    for (int c = 1; c <= limit; c++) begin
      @(posedge clk);
      #1;
      if (done1) begin
        lat = c + 1;
        break;
      end
    end
  endtask

  task automatic freq_run(input string tag);
    int lat;
    kick(1'b0);
    wait_done1(3000, lat);
    $display("[TB] %s: latency=%0d val=%h ovf=%b", tag, lat, val1, ovf1);
    chk({tag, "_latency"}, lat, 64'd1002);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_val"}, {48'd0, val1[i*16 +: 16]}, exp_f[i]);
    end
    chk({tag, "_ovf"}, {60'd0, ovf1}, 64'd0);
    @(posedge clk);
    #1;
    chk({tag, "_done_one_cycle"}, {62'd0, done1, busy1}, 64'd0);
  endtask

  initial begin
    int lat1, lat2, nd;
    per   = '{10, 20, 50, 1000};
    ph    = '{0, 0, 0, 0};
    rst_n = 1'b0;
    start = 1'b0;
    mode  = 1'b0;
    abort = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", {62'd0, busy1, busy2}, 64'd0);
    chk("rst_done", {62'd0, done1, done2}, 64'd0);
    chk("rst_val1", val1, 64'd0);
    chk("rst_val2", {32'd0, val2}, 64'd0);
    chk("rst_ovf", {56'd0, ovf1, ovf2}, 64'd0);
    chk("rst_timeout", {56'd0, tmo1, tmo2}, 64'd0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // Frequency mode
    freq_run("freq");

    // Period mode: dut1 4x37 -> 148, dut2 period 300 saturates at 255
    per = '{37, 37, 37, 37};
    repeat (50) @(negedge clk);
    kick(1'b1);
    lat1 = -1;
    lat2 = -1;
    for (int c = 1; c <= 3000; c++) begin
      @(posedge clk);
      #1;
      if (done1 && lat1 < 0) lat1 = c + 1;
      if (done2 && lat2 < 0) begin
        lat2 = c + 1;
        chk("sat_val2", {32'd0, val2}, 64'h0000_0000_FFFF_FFFF);
        chk("sat_ovf2", {60'd0, ovf2}, 64'hF);
      end
      if (lat1 >= 0 && lat2 >= 0) break;
    end
    $display("[TB] period: lat1=%0d val1=%h ovf1=%b lat2=%0d val2=%h ovf2=%b",
             lat1, val1, ovf1, lat2, val2, ovf2);
    chk("period_done1_seen", {63'd0, (lat1 > 0)}, 64'd1);
    chk("sat_done2_seen", {63'd0, (lat2 > 0)}, 64'd1);
    for (int i = 0; i < 4; i++) begin
      chk("period_val", {48'd0, val1[i*16 +: 16]}, 64'd148);
    end
    chk("period_ovf", {60'd0, ovf1}, 64'd0);
    chk("period_timeout", {60'd0, tmo1}, 64'd0);

    // Abort 500 cycles into a frequency run
    per = '{10, 20, 50, 1000};
    repeat (10) @(negedge clk);
    kick(1'b0);
    repeat (499) @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    $display("[TB] abort: busy=%b done=%b val=%h", busy1, done1, val1);
    chk("abort_busy", {62'd0, busy1, done1}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk("abort_val_kept", {48'd0, val1[i*16 +: 16]}, 64'd148);
    end
    nd = 0;
    for (int c = 0; c < 1100; c++) begin
      @(posedge clk);
      #1;
      if (done1) nd++;
    end
    chk("abort_no_done", nd, 64'd0);

    // Reset in the middle of MEASURE
    kick(1'b0);
    repeat (200) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    $display("[TB] mid-reset: busy=%b done=%b val=%h ovf=%b", busy1, done1, val1, ovf1);
    chk("midrst_busy", {62'd0, busy1, done1}, 64'd0);
    chk("midrst_val", val1, 64'd0);
    chk("midrst_ovf", {60'd0, ovf1}, 64'd0);
    chk("midrst_val2", {32'd0, val2}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    freq_run("freq_after_reset");

`ifdef FMEAS_TIMEOUT_EN
    // Period mode with channel 2 held low -> timeout
    per = '{37, 37, 0, 37};
    repeat (50) @(negedge clk);
    kick(1'b1);
    wait_done1(6000, lat1);
    $display("[TB] timeout: lat=%0d val=%h ovf=%b timeout=%b", lat1, val1, ovf1, tmo1);
    chk("tmo_latency", lat1, 64'd5002);
    chk("tmo_flags", {60'd0, tmo1}, 64'b0100);
    chk("tmo_val2", {48'd0, val1[32 +: 16]}, 64'd0);
    chk("tmo_val0", {48'd0, val1[0 +: 16]}, 64'd148);
    chk("tmo_ovf", {60'd0, ovf1}, 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
